// File: rtl/display_pkg.sv
// Shared definitions for the two-source 3-digit display arbiter: FSM encoding,
// active-low segment codes, digit enables and the double-dabble step.
package display_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_CONV  = 2'd2,
        S_LATCH = 2'd3
    } state_e;

    localparam logic [7:0] SEG_BLANK    = 8'hFF;
    localparam logic [3:0] BCD_BLANK    = 4'hF;
    localparam logic [7:0] DIG_UNITS    = 8'hFE;
    localparam logic [7:0] DIG_TENS     = 8'hFD;
    localparam logic [7:0] DIG_HUNDREDS = 8'hFB;

    // {dp,g,f,e,d,c,b,a}, active low, digits 0..9
    localparam logic [7:0] SEG_TABLE [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h98
    };

    // One shift-add-3 iteration on {hundreds, tens, units, binary}.
    function automatic logic [19:0] dabble_step(input logic [19:0] v);
        logic [19:0] r;
        r = v;
        for (int i = 0; i < 3; i++) begin
            if (r[8+4*i +: 4] >= 4'd5)
                r[8+4*i +: 4] = r[8+4*i +: 4] + 4'd3;
        end
        return {r[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment code; codes above 9 render blank.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (bcd_i <= 4'd9)
            seg_o = SEG_TABLE[bcd_i];
    end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin arbiter between two 8-bit sources feeding a multiplexed
// 3-digit 7-segment display via a serial binary-to-BCD converter.
module display_arbiter
    import display_pkg::*;
#(
    parameter int CLK_DIV = 100000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Req0,
    input  logic [7:0] Dato0,
    input  logic       Req1,
    input  logic [7:0] Dato1,
    output logic       Ack0,
    output logic       Ack1,
    output logic       Busy,
    output logic       Fuente,
    output logic [7:0] Displays,
    output logic [7:0] Segmentos
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    state_e        state_q;
    logic          ack0_q, ack1_q, busy_q, fuente_q;
    logic          last_q, gnt_q;
    logic [7:0]    val_q;
    logic [19:0]   dd_q;
    logic [2:0]    cnt_q;
    logic [11:0]   disp_q, disp_d;
    logic          win;

    logic [PW-1:0] presc_q;
    logic [1:0]    idx_q, idx_d;
    logic          presc_wrap;
    logic [7:0]    dig_q, dig_d, seg_q, seg_dec;
    logic [3:0]    code;

    // On a tie the source that was not served last wins.
    assign win    = (Req0 && Req1) ? ~last_q : Req1;
    assign disp_d = (state_q == S_LATCH) ? dd_q[19:8] : disp_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= S_IDLE;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
            fuente_q <= 1'b0;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            val_q    <= '0;
            dd_q     <= '0;
            cnt_q    <= '0;
            disp_q   <= '0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            disp_q <= disp_d;
            case (state_q)
                S_IDLE: begin
                    if (Req0 || Req1) begin
                        state_q <= S_GRANT;
                        busy_q  <= 1'b1;
                        gnt_q   <= win;
                        val_q   <= win ? Dato1 : Dato0;
                        ack0_q  <= ~win;
                        ack1_q  <= win;
                    end
                end
                S_GRANT: begin
                    state_q <= S_CONV;
                    dd_q    <= {12'd0, val_q};
                    cnt_q   <= '0;
                end
                S_CONV: begin
                    dd_q  <= dabble_step(dd_q);
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7)
                        state_q <= S_LATCH;
                end
                S_LATCH: begin
                    state_q  <= S_IDLE;
                    busy_q   <= 1'b0;
                    fuente_q <= gnt_q;
                    last_q   <= gnt_q;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign presc_wrap = (presc_q == PW'(CLK_DIV - 1));

    // Segments are decoded from next-state digit/index so both registers
    // switch on the same edge.
    always_comb begin
        idx_d = idx_q;
        if (presc_wrap)
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        dig_d = DIG_UNITS;
        code  = disp_d[3:0];
        case (idx_d)
            2'd1: begin
                dig_d = DIG_TENS;
                code  = (disp_d[11:4] == 8'd0) ? BCD_BLANK : disp_d[7:4];
            end
            2'd2: begin
                dig_d = DIG_HUNDREDS;
                code  = (disp_d[11:8] == 4'd0) ? BCD_BLANK : disp_d[11:8];
            end
            default: ;
        endcase
    end

    seg7_decode u_dec (
        .bcd_i (code),
        .seg_o (seg_dec)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
            dig_q   <= DIG_UNITS;
            seg_q   <= SEG_TABLE[0];
        end else begin
            presc_q <= presc_wrap ? '0 : presc_q + PW'(1);
            idx_q   <= idx_d;
            dig_q   <= dig_d;
            seg_q   <= seg_dec;
        end
    end

    assign Ack0      = ack0_q;
    assign Ack1      = ack1_q;
    assign Busy      = busy_q;
    assign Fuente    = fuente_q;
    assign Displays  = dig_q;
    assign Segmentos = seg_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: directed vector table, multi-cycle
// corner sequences and randomized transactions against a decimal-digit model.
module tb_display_arbiter;

    localparam int CLK_DIV = 4;
    localparam logic [7:0] SEGS [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h98
    };

    logic       Clk, Rst, Req0, Req1, Ack0, Ack1, Busy, Fuente;
    logic [7:0] Dato0, Dato1, Displays, Segmentos;

    int  total = 0;
    int  bad   = 0;
    bit  m_last;

    display_arbiter #(.CLK_DIV(CLK_DIV)) dut (
        .Clk(Clk), .Rst(Rst), .Req0(Req0), .Dato0(Dato0), .Req1(Req1),
        .Dato1(Dato1), .Ack0(Ack0), .Ack1(Ack1), .Busy(Busy),
        .Fuente(Fuente), .Displays(Displays), .Segmentos(Segmentos)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        bit         src;
        logic [7:0] val;
        logic [7:0] fe, fd, fb;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected segments for a value at digit position 0/1/2, from decimal arithmetic.
    function automatic logic [7:0] mseg(input int v, input int pos);
        if (pos == 0) return SEGS[v % 10];
        if (pos == 1) return (v < 10) ? 8'hFF : SEGS[(v / 10) % 10];
        return (v < 100) ? 8'hFF : SEGS[v / 100];
    endfunction

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1; Req0 = 1'b0; Req1 = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        m_last = 1'b1;
    endtask

    // Entered just after the request was driven; checks Ack, Busy window, Fuente.
    task automatic serve(input bit src);
        bit ok;
        @(negedge Clk);
        chk("ack_grant", {Ack1, Ack0}, src ? 2'b10 : 2'b01);
        chk("busy_at_ack", Busy, 1'b1);
        if (src) Req1 = 1'b0; else Req0 = 1'b0;
        ok = 1'b1;
        for (int i = 1; i < 10; i++) begin
            @(negedge Clk);
            if (Busy !== 1'b1 || Ack0 !== 1'b0 || Ack1 !== 1'b0) ok = 1'b0;
        end
        chk("busy_window", ok, 1'b1);
        @(negedge Clk);
        chk("busy_done", {Busy, Ack1, Ack0}, 3'b000);
        chk("fuente", Fuente, src);
        m_last = src;
    endtask

    task automatic check_scan(input logic [7:0] fe, input logic [7:0] fd, input logic [7:0] fb);
        logic [2:0] seen;
        seen = '0;
        for (int i = 0; i < 3 * CLK_DIV; i++) begin
            @(negedge Clk);
            case (Displays)
                8'hFE: begin chk("seg_units", Segmentos, fe); seen[0] = 1'b1; end
                8'hFD: begin chk("seg_tens", Segmentos, fd); seen[1] = 1'b1; end
                8'hFB: begin chk("seg_hundreds", Segmentos, fb); seen[2] = 1'b1; end
                default: chk("scan_enable", Displays, 8'hFE);
            endcase
        end
        chk("scan_all_digits", seen, 3'b111);
    endtask

    task automatic run_txn(input bit r0, input bit r1, input logic [7:0] d0, input logic [7:0] d1);
        bit first;
        logic [7:0] fin;
        first = (r0 && r1) ? ~m_last : r1;
        @(negedge Clk);
        Req0 = r0; Req1 = r1; Dato0 = d0; Dato1 = d1;
        serve(first);
        fin = first ? d1 : d0;
        if (r0 && r1) begin
            serve(~first);
            fin = first ? d0 : d1;
        end
        check_scan(mseg(fin, 0), mseg(fin, 1), mseg(fin, 2));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        bit ok;
        logic [7:0] prev, exp_next;
        int run;
        bit first_run;

        vecs[0] = '{src: 1'b0, val: 8'd249, fe: 8'h98, fd: 8'h99, fb: 8'hA4};
        vecs[1] = '{src: 1'b0, val: 8'd7,   fe: 8'hF8, fd: 8'hFF, fb: 8'hFF};
        vecs[2] = '{src: 1'b0, val: 8'd0,   fe: 8'hC0, fd: 8'hFF, fb: 8'hFF};
        vecs[3] = '{src: 1'b0, val: 8'd255, fe: 8'h92, fd: 8'h92, fb: 8'hA4};
        vecs[4] = '{src: 1'b1, val: 8'd10,  fe: 8'hC0, fd: 8'hF9, fb: 8'hFF};
        vecs[5] = '{src: 1'b1, val: 8'd100, fe: 8'hC0, fd: 8'hC0, fb: 8'hF9};

        Rst = 1'b1; Req0 = 1'b0; Req1 = 1'b0; Dato0 = '0; Dato1 = '0;
        m_last = 1'b1;
        repeat (2) @(negedge Clk);
        chk("rst_displays", Displays, 8'hFE);
        chk("rst_segmentos", Segmentos, 8'hC0);
        chk("rst_flags", {Ack0, Ack1, Busy, Fuente}, 4'b0000);
        Rst = 1'b0;

        // Directed single-source vectors
        for (int v = 0; v < 6; v++) begin
            @(negedge Clk);
            if (vecs[v].src) begin Req1 = 1'b1; Dato1 = vecs[v].val; end
            else             begin Req0 = 1'b1; Dato0 = vecs[v].val; end
            serve(vecs[v].src);
            check_scan(vecs[v].fe, vecs[v].fd, vecs[v].fb);
        end

        // Simultaneous requests straight after reset: source 0 first, then 1
        do_reset();
        @(negedge Clk);
        Req0 = 1'b1; Dato0 = 8'd5; Req1 = 1'b1; Dato1 = 8'd200;
        serve(1'b0);
        serve(1'b1);
        check_scan(8'hC0, 8'hC0, 8'hA4);
        chk("fuente_after_tie", Fuente, 1'b1);

        // Reset mid-conversion aborts the transaction
        @(negedge Clk);
        Req1 = 1'b1; Dato1 = 8'd123;
        @(negedge Clk);
        chk("abort_ack1", {Ack1, Ack0}, 2'b10);
        Req1 = 1'b0;
        repeat (4) @(negedge Clk);
        chk("abort_busy_before", Busy, 1'b1);
        Rst = 1'b1;
        @(negedge Clk);
        chk("abort_busy", Busy, 1'b0);
        chk("abort_digit", Displays, 8'hFE);
        chk("abort_seg", Segmentos, 8'hC0);
        Rst = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge Clk);
            if (Ack0 !== 1'b0 || Ack1 !== 1'b0 || Busy !== 1'b0) ok = 1'b0;
        end
        chk("abort_no_ack", ok, 1'b1);
        check_scan(8'hC0, 8'hFF, 8'hFF);

        // Free-running scan order and dwell
        @(negedge Clk);
        prev = Displays; run = 1; first_run = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk);
            chk("free_scan_valid", (Displays == 8'hFE || Displays == 8'hFD || Displays == 8'hFB), 1'b1);
            if (Displays !== prev) begin
                exp_next = (prev == 8'hFE) ? 8'hFD : (prev == 8'hFD) ? 8'hFB : 8'hFE;
                chk("free_scan_order", Displays, exp_next);
                if (!first_run) chk("free_scan_dwell", run, CLK_DIV);
                first_run = 1'b0;
                run = 1;
                prev = Displays;
            end else begin
                run++;
            end
        end

        // Randomized transactions against the model
        do_reset();
        for (int n = 0; n < 16; n++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            run_txn(mode != 1, mode != 0, 8'($urandom), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
